// File: rtl/cart_loader_if.sv
// Bus bundle between the download block, the console CPU cartridge port and cart_loader.
// The slave side is the loader; the master side is its environment.
interface cart_loader_if;
  logic        dl_active;
  logic [15:0] dl_size;
  logic [10:0] cpu_addr;
  logic [1:0]  cpu_bank;
  logic [12:0] ram_a;
  logic [7:0]  ram_q;
  logic        cpu_rst;
  logic        cart_valid;
  logic [1:0]  cart_mask;
  logic [7:0]  checksum;

  modport slave (
    input  dl_active, dl_size, cpu_addr, cpu_bank, ram_q,
    output ram_a, cpu_rst, cart_valid, cart_mask, checksum
  );

  modport master (
    output dl_active, dl_size, cpu_addr, cpu_bank, ram_q,
    input  ram_a, cpu_rst, cart_valid, cart_mask, checksum
  );
endinterface

// File: rtl/cart_loader.sv
// Videopac cartridge loader: holds the CPU in reset during ROM download, checksums
// the loaded image, then maps banked CPU cartridge addresses onto the download RAM.
module cart_loader #(
  parameter logic [15:0] HOLD_CYCLES = 16'd1024
) (
  input  logic          clk,
  input  logic          reset_n,
  cart_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    LOAD = 3'd0,
    SIZE = 3'd1,
    SCAN = 3'd2,
    HOLD = 3'd3,
    RUN  = 3'd4
  } state_t;

  state_t      state_r;
  logic        sync_s1_r;
  logic        sync_s2_r;
  logic        sync_s3_r;
  logic [15:0] hold_cnt_r;
  logic [13:0] scan_cnt_r;
  logic [13:0] size_r;
  logic [7:0]  acc_r;
  logic        rd_vld_r;
  logic        rd_last_r;
  logic        cpu_rst_r;
  logic        cart_valid_r;
  logic [1:0]  cart_mask_r;
  logic [7:0]  checksum_r;

  logic        rise_s;
  logic        fall_s;
  logic [13:0] clamp_size_s;
  logic [1:0]  mask_s;
  logic [12:0] ram_a_s;

  assign rise_s = sync_s2_r & ~sync_s3_r;
  assign fall_s = ~sync_s2_r & sync_s3_r;

  // Clamp the byte count to the 8 KB RAM and derive the bank mask from it.
  always_comb begin
    clamp_size_s = 14'd0;
    mask_s       = 2'b00;
    if (bus.dl_size > 16'd8192) begin
      clamp_size_s = 14'd8192;
    end else begin
      clamp_size_s = bus.dl_size[13:0];
    end
    if (clamp_size_s <= 14'd2048) begin
      mask_s = 2'b00;
    end else if (clamp_size_s <= 14'd4096) begin
      mask_s = 2'b01;
    end else begin
      mask_s = 2'b11;
    end
  end

  // RAM address: scan counter while checksumming, banked CPU mapping otherwise.
  always_comb begin
    ram_a_s = 13'd0;
    if (!reset_n) begin
      ram_a_s = 13'd0;
    end else if (state_r == SCAN) begin
      ram_a_s = scan_cnt_r[12:0];
    end else begin
      ram_a_s = {bus.cpu_bank & cart_mask_r, bus.cpu_addr};
    end
  end

  // Two-flop synchroniser for dl_active plus an edge-detect flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_s1_r <= 1'b0;
      sync_s2_r <= 1'b0;
      sync_s3_r <= 1'b0;
    end else begin
      sync_s1_r <= bus.dl_active;
      sync_s2_r <= sync_s1_r;
      sync_s3_r <= sync_s2_r;
    end
  end

  // Load/scan/hold/run sequencer with registered CPU-side outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= HOLD;
      hold_cnt_r   <= 16'd0;
      scan_cnt_r   <= 14'd0;
      size_r       <= 14'd0;
      acc_r        <= 8'h00;
      rd_vld_r     <= 1'b0;
      rd_last_r    <= 1'b0;
      cpu_rst_r    <= 1'b1;
      cart_valid_r <= 1'b0;
      cart_mask_r  <= 2'b00;
      checksum_r   <= 8'h00;
    end else if (rise_s) begin
      // A new download wins over everything, including a pending release.
      state_r      <= LOAD;
      cpu_rst_r    <= 1'b1;
      cart_valid_r <= 1'b0;
      rd_vld_r     <= 1'b0;
      rd_last_r    <= 1'b0;
    end else begin
      case (state_r)
        LOAD: begin
          cpu_rst_r    <= 1'b1;
          cart_valid_r <= 1'b0;
          if (fall_s) begin
            state_r <= SIZE;
          end else begin
            state_r <= LOAD;
          end
        end
        SIZE: begin
          cpu_rst_r  <= 1'b1;
          size_r     <= clamp_size_s;
          acc_r      <= 8'h00;
          scan_cnt_r <= 14'd0;
          rd_vld_r   <= 1'b0;
          rd_last_r  <= 1'b0;
          if (clamp_size_s == 14'd0) begin
            checksum_r   <= 8'h00;
            cart_valid_r <= 1'b0;
            cart_mask_r  <= 2'b00;
            hold_cnt_r   <= 16'd0;
            state_r      <= HOLD;
          end else begin
            cart_mask_r <= mask_s;
            state_r     <= SCAN;
          end
        end
        SCAN: begin
          cpu_rst_r <= 1'b1;
          if (scan_cnt_r < size_r) begin
            scan_cnt_r <= scan_cnt_r + 14'd1;
            rd_vld_r   <= 1'b1;
            rd_last_r  <= (scan_cnt_r == size_r - 14'd1);
          end else begin
            rd_vld_r  <= 1'b0;
            rd_last_r <= 1'b0;
          end
          // RAM data lags its address by one clock, so accumulate the flagged byte.
          if (rd_vld_r) begin
            acc_r <= acc_r + bus.ram_q;
            if (rd_last_r) begin
              checksum_r   <= acc_r + bus.ram_q;
              cart_valid_r <= 1'b1;
              hold_cnt_r   <= 16'd0;
              state_r      <= HOLD;
            end else begin
              state_r <= SCAN;
            end
          end else begin
            state_r <= SCAN;
          end
        end
        HOLD: begin
          if (hold_cnt_r == HOLD_CYCLES - 16'd1) begin
            cpu_rst_r <= 1'b0;
            state_r   <= RUN;
          end else begin
            cpu_rst_r  <= 1'b1;
            hold_cnt_r <= hold_cnt_r + 16'd1;
            state_r    <= HOLD;
          end
        end
        RUN: begin
          cpu_rst_r <= 1'b0;
          state_r   <= RUN;
        end
        default: begin
          cpu_rst_r  <= 1'b1;
          hold_cnt_r <= 16'd0;
          state_r    <= HOLD;
        end
      endcase
    end
  end

  assign bus.ram_a      = ram_a_s;
  assign bus.cpu_rst    = cpu_rst_r;
  assign bus.cart_valid = cart_valid_r;
  assign bus.cart_mask  = cart_mask_r;
  assign bus.checksum   = checksum_r;

endmodule

// File: tb/tb_cart_loader.sv
// Directed bench for cart_loader: downloads, checksums, bank mapping, abort and reset.
module tb_cart_loader;
  localparam logic [15:0] HOLD = 16'd8;
  localparam int          HOLD_N = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   cnt;

  cart_loader_if bus();

  cart_loader #(.HOLD_CYCLES(HOLD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:8191];

  // Download RAM read port: data one clock after the address.
  always @(posedge clk) bus.ram_q <= mem[bus.ram_a];

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < 8192; i++) begin
      case (mode)
        0:       mem[i] = 8'h01;
        1:       mem[i] = 8'(i);
        2:       mem[i] = 8'h03;
        default: mem[i] = 8'h00;
      endcase
    end
  endtask

  task automatic start_dl();
    @(negedge clk);
    bus.dl_active = 1'b1;
    repeat (5) @(negedge clk);
    chk_vec("load_cpu_rst", bus.cpu_rst, 1'b1);
    chk_vec("load_valid", bus.cart_valid, 1'b0);
  endtask

  task automatic end_dl_scan(input int size, input int n);
    int c;
    bus.dl_size = 16'(size);
    @(negedge clk);
    bus.dl_active = 1'b0;
    c = 0;
    do begin
      @(posedge clk); #1;
      c++;
    end while (!bus.cart_valid && c < n + 20);
    chk_vec("scan_lat", c, n + 5);
    c = 0;
    do begin
      @(posedge clk); #1;
      c++;
    end while (bus.cpu_rst && c < HOLD_N + 5);
    chk_vec("hold_len", c, HOLD_N);
  endtask

  initial begin
    bus.dl_active = 1'b0;
    bus.dl_size   = 16'd0;
    bus.cpu_addr  = 11'h5A5;
    bus.cpu_bank  = 2'd3;
    fill(0);

    // Reset values, then release with no download
    #12;
    chk_vec("rst_cpu_rst", bus.cpu_rst, 1'b1);
    chk_vec("rst_valid", bus.cart_valid, 1'b0);
    chk_vec("rst_mask", bus.cart_mask, 2'b00);
    chk_vec("rst_checksum", bus.checksum, 8'h00);
    chk_vec("rst_ram_a", bus.ram_a, 13'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (bus.cpu_rst && cnt < HOLD_N + 5);
    chk_vec("boot_hold", cnt, HOLD_N);
    chk_vec("boot_valid", bus.cart_valid, 1'b0);
    chk_vec("boot_checksum", bus.checksum, 8'h00);

    // 2048 bytes of 0x01
    start_dl();
    end_dl_scan(2048, 2048);
    chk_vec("d2k_mask", bus.cart_mask, 2'b00);
    chk_vec("d2k_checksum", bus.checksum, 8'h00);
    chk_vec("d2k_valid", bus.cart_valid, 1'b1);
    bus.cpu_bank = 2'd3; bus.cpu_addr = 11'h7FF; #1;
    chk_vec("d2k_map", bus.ram_a, 13'h07FF);

    // 4096 bytes of i & 0xFF
    start_dl();
    fill(1);
    end_dl_scan(4096, 4096);
    chk_vec("d4k_mask", bus.cart_mask, 2'b01);
    chk_vec("d4k_checksum", bus.checksum, 8'h00);
    bus.cpu_bank = 2'd3; bus.cpu_addr = 11'h005; #1;
    chk_vec("d4k_map_b3", bus.ram_a, 13'h0805);
    bus.cpu_bank = 2'd2; #1;
    chk_vec("d4k_map_b2", bus.ram_a, 13'h0005);

    // Oversized count clamps to 8192 bytes of 0x03
    start_dl();
    fill(2);
    end_dl_scan(9000, 8192);
    chk_vec("d8k_mask", bus.cart_mask, 2'b11);
    chk_vec("d8k_checksum", bus.checksum, 8'h00);
    bus.cpu_bank = 2'd2; bus.cpu_addr = 11'h123; #1;
    chk_vec("d8k_map", bus.ram_a, 13'h1123);

    // Three bytes FF 02 10
    start_dl();
    mem[0] = 8'hFF; mem[1] = 8'h02; mem[2] = 8'h10;
    end_dl_scan(3, 3);
    chk_vec("d3_checksum", bus.checksum, 8'h11);
    chk_vec("d3_mask", bus.cart_mask, 2'b00);
    chk_vec("d3_valid", bus.cart_valid, 1'b1);
    bus.cpu_bank = 2'd3; bus.cpu_addr = 11'h7FF; #1;
    chk_vec("d3_map", bus.ram_a, 13'h07FF);

    // New download aborts a scan, then an empty image
    bus.cpu_bank = 2'd0; bus.cpu_addr = 11'h7FF;
    start_dl();
    fill(1);
    bus.dl_size = 16'd4096;
    @(negedge clk);
    bus.dl_active = 1'b0;
    repeat (10) @(negedge clk);
    bus.dl_active = 1'b1;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (bus.ram_a != 13'h07FF && cnt < 10);
    chk_vec("abort_lat", (cnt >= 2 && cnt <= 4), 1'b1);
    chk_vec("abort_valid", bus.cart_valid, 1'b0);
    chk_vec("abort_checksum", bus.checksum, 8'h11);
    chk_vec("abort_cpu_rst", bus.cpu_rst, 1'b1);
    repeat (3) @(negedge clk);
    bus.dl_size = 16'd0;
    @(negedge clk);
    bus.dl_active = 1'b0;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (bus.cpu_rst && cnt < HOLD_N + 20);
    chk_vec("empty_release", cnt, HOLD_N + 4);
    chk_vec("empty_valid", bus.cart_valid, 1'b0);
    chk_vec("empty_checksum", bus.checksum, 8'h00);
    chk_vec("empty_mask", bus.cart_mask, 2'b00);

    // Restore a non-zero checksum, then reset in the middle of a scan
    start_dl();
    mem[0] = 8'hFF; mem[1] = 8'h02; mem[2] = 8'h10;
    end_dl_scan(3, 3);
    chk_vec("d3b_checksum", bus.checksum, 8'h11);
    start_dl();
    fill(1);
    bus.dl_size = 16'd4096;
    @(negedge clk);
    bus.dl_active = 1'b0;
    repeat (10) @(negedge clk);
    bus.cpu_bank = 2'd3; bus.cpu_addr = 11'h7FF;
    chk_vec("pre_rst_mask", bus.cart_mask, 2'b01);
    reset_n = 1'b0;
    #1;
    chk_vec("mid_rst_cpu_rst", bus.cpu_rst, 1'b1);
    chk_vec("mid_rst_valid", bus.cart_valid, 1'b0);
    chk_vec("mid_rst_mask", bus.cart_mask, 2'b00);
    chk_vec("mid_rst_checksum", bus.checksum, 8'h00);
    chk_vec("mid_rst_ram_a", bus.ram_a, 13'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (bus.cpu_rst && cnt < HOLD_N + 5);
    chk_vec("post_rst_hold", cnt, HOLD_N);
    chk_vec("post_rst_valid", bus.cart_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cart_loader.md
# cart_loader

Sits between the SPI download RAM block and the console CPU's cartridge bus in the Videopac core. It synchronises the download-active flag into the system clock domain and holds the CPU in reset while a ROM is loading. When loading ends it latches the byte count, derives the bank mask, and sweeps the loaded image to compute an 8-bit checksum. After that it releases the CPU and maps banked CPU cartridge addresses onto the 13-bit RAM read port.

## Interface
Parameters:
- HOLD_CYCLES, default 16'd1024: clk cycles cpu_rst stays asserted after scan (or after reset) before release; must be ≥ 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- dl_active  in  1  download-active flag from the SPI clock domain; asynchronous to clk.
- dl_size  in  16  byte count from the download block; stable whenever dl_active is low.
- cpu_addr  in  11  CPU cartridge address within a 2 KB window.
- cpu_bank  in  2  CPU bank select (P10/P11).
- ram_a  out  13  read address to the download RAM CPU port.
- ram_q  in  8  RAM read data; valid one clk after ram_a.
- cpu_rst  out  1  active-high CPU reset.
- cart_valid  out  1  a non-empty image is loaded and scanned.
- cart_mask  out  2  bank mask applied to cpu_bank.
- checksum  out  8  mod-256 sum of image bytes.

## Operation
- Reset values: cpu_rst=1, cart_valid=0, cart_mask=2'b00, checksum=8'h00, ram_a=0, state=HOLD, hold counter=0, sync flops=0.
- CDC: dl_active passes through a 2-FF synchroniser (s1, s2), then a third flop s3. rise = s2&~s3, fall = ~s2&s3.
- dl_size is only sampled in SIZE, where it is quasi-static by protocol. No multi-bit synchroniser is used.
- States:
  - LOAD: cpu_rst=1, cart_valid=0. Go to SIZE on fall.
  - SIZE: one cycle. Latch n = min(dl_size, 8192).
    - cart_mask = 00 if n≤2048, 01 if n≤4096, else 11.
    - Clear the accumulator and scan counter.
    - If n==0: checksum=0, cart_valid=0, cart_mask=00, go to HOLD. Otherwise go to SCAN.
  - SCAN: ram_a = scan counter, counting 0..n-1, one address per cycle.
    - The accumulator adds ram_q one cycle later through a valid pipeline flag.
    - After the byte at n-1 is accumulated: latch checksum, set cart_valid=1, go to HOLD.
  - HOLD: cpu_rst=1. Hold counter counts 0..HOLD_CYCLES-1, then go to RUN.
  - RUN: cpu_rst=0. ram_a = {cpu_bank & cart_mask, cpu_addr} combinationally.
- rise in any state forces LOAD on the next edge.
  - This includes mid-SCAN and mid-HOLD. The partial sum is discarded; checksum keeps its last latched value until the next SIZE.
  - A new download invalidates the image immediately (cart_valid→0 on entry to LOAD).
- In LOAD, SIZE and HOLD, ram_a follows the RUN mapping formula. It is don't-care to the CPU, which is held in reset.
- Arithmetic: the accumulator is 8 bits and wraps mod 256. The scan counter is 14 bits so it can reach 8192.
- reset_n asserted in any state returns all outputs to their reset values asynchronously. cpu_rst goes high within the same reset assertion.

## Timing
- dl_active edge to rise/fall: 2–3 clk. Latency from rise to cpu_rst=1 ≤ 4 clk (already 1 unless in RUN).
- fall to SIZE: 1 clk. SCAN lasts n+1 clk (n addresses plus 1 pipeline drain).
- checksum/cart_valid update on the same edge as SCAN→HOLD.
- cpu_rst falls exactly HOLD_CYCLES clk after HOLD entry.
- RUN mapping is combinational: ram_a changes in the same cycle as cpu_addr/cpu_bank. Read data arrives one clk later.
- Simultaneous rise and HOLD→RUN: LOAD wins and cpu_rst stays 1.

## Test plan
- Reset release, no download → cpu_rst=1 for exactly HOLD_CYCLES clk, then 0. cart_valid=0, checksum=00.
- Download 2048 bytes, all 8'h01 (dl_size=2048) → cart_mask=00, checksum=8'h00 (2048 mod 256), cart_valid=1. In RUN, cpu_bank=3, cpu_addr=0x7FF gives ram_a=0x07FF.
- Download 4096 bytes of value i&0xFF → checksum=8'h00, cart_mask=01. cpu_bank=2'b11, cpu_addr=5 gives ram_a=0x0805.
- dl_size=3 with bytes 0xFF,0x02,0x10 → checksum=0x11, SCAN lasts 4 clk, cart_mask=00.
- Second download rises mid-SCAN → LOAD within 4 clk, cart_valid=0, checksum keeps the previous value. After fall with dl_size=0: cart_valid=0, checksum=00, then HOLD and RUN.
- reset_n pulsed low mid-SCAN → all outputs at reset values immediately. After release: HOLD for HOLD_CYCLES, then RUN with cart_valid=0.
